mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 multiplexer's single output among four requesters. It sits directly in front of the multiplexer's select inputs. It turns four request lines into a one-hot grant and drives the matching `address0`/`address1` pair. Tenure is bounded by a programmable hold limit, so one requester cannot starve the others.

---
 rtl/mux_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 mux.
// Registered one-hot grants; each grant's tenure is capped at MAXHOLD cycles.
module mux_rr_arbiter #(
  parameter int unsigned MAXHOLD = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  output logic grant0,
  output logic grant1,
  output logic grant2,
  output logic grant3,
  output logic address0,
  output logic address1,
  output logic busy
);

  localparam logic [7:0] HoldLast = 8'(MAXHOLD - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  count_q, count_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  addr_q, addr_d;

  logic [3:0]  req;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic        release_grant;

  assign req = {req3, req2, req1, req0};

  // Search last+1, last+2, last+3, last; the 2-bit add wraps naturally.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = base;
    for (int i = 1; i <= 4; i++) begin
      cand = base + 2'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // In StGrant last_q always equals owner_q, so one pick serves both states.
  assign {pick_valid, pick_idx} = rr_pick(req, last_q);

  assign release_grant = !req[owner_q] || (count_q == HoldLast);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          owner_d = pick_idx;
          last_d  = pick_idx;
          count_d = 8'd0;
          grant_d = 4'b0001 << pick_idx;
          addr_d  = pick_idx;
        end
      end
      StGrant: begin
        if (!release_grant) begin
          count_d = count_q + 8'd1;
        end else if (pick_valid) begin
          owner_d = pick_idx;
          last_d  = pick_idx;
          count_d = 8'd0;
          grant_d = 4'b0001 << pick_idx;
          addr_d  = pick_idx;
        end else begin
          state_d = StIdle;
          grant_d = 4'b0000;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      count_q <= 8'd0;
      grant_q <= 4'b0000;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
    end
  end

  assign grant0   = grant_q[0];
  assign grant1   = grant_q[1];
  assign grant2   = grant_q[2];
  assign grant3   = grant_q[3];
  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign busy     = (state_q == StGrant);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAXHOLD=8; outputs sampled on falling edges.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, req3 = 1'b0;
  logic grant0, grant1, grant2, grant3;
  logic address0, address1, busy;
  logic [3:0] g;
  logic [1:0] addr;

  int vectors = 0;
  int miscompares = 0;

  mux_rr_arbiter #(.MAXHOLD(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .req2     (req2),
    .req3     (req3),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant2   (grant2),
    .grant3   (grant3),
    .address0 (address0),
    .address1 (address1),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign g    = {grant3, grant2, grant1, grant0};
  assign addr = {address1, address0};

  task automatic set_req(input logic [3:0] r);
    {req3, req2, req1, req0} = r;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_req(4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({g, addr, busy} !== 7'b0000_00_0) begin
      miscompares++;
      $display("FAIL reset: grant=%b addr=%b busy=%b, required grant=0000 addr=00 busy=0",
               g, addr, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(4'b0100);
    @(negedge clk);
    vectors++;
    if ({g, addr, busy} !== 7'b0100_10_1) begin
      miscompares++;
      $display("FAIL single_grant: grant=%b addr=%b busy=%b, required 0100 10 1", g, addr, busy);
    end
    set_req(4'b0000);
    @(negedge clk);
    vectors++;
    if ({g, addr, busy} !== 7'b0000_10_0) begin
      miscompares++;
      $display("FAIL single_release: grant=%b addr=%b busy=%b, required 0000 10 0",
               g, addr, busy);
    end
  endtask

  task automatic test_rotate();
    logic [1:0] exp_owner;
    do_reset();
    set_req(4'b1111);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      exp_owner = 2'((k / 8) % 4);
      vectors++;
      if (g !== (4'b0001 << exp_owner) || addr !== exp_owner || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rotate[%0d]: grant=%b addr=%b busy=%b, required grant=%b addr=%b busy=1",
                 k, g, addr, busy, 4'b0001 << exp_owner, exp_owner);
      end
    end
    set_req(4'b0000);
    @(negedge clk);
  endtask

  task automatic test_sole();
    do_reset();
    set_req(4'b0010);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      vectors++;
      if ({g, addr, busy} !== 7'b0010_01_1) begin
        miscompares++;
        $display("FAIL sole[%0d]: grant=%b addr=%b busy=%b, required 0010 01 1",
                 k, g, addr, busy);
      end
    end
    set_req(4'b0000);
    @(negedge clk);
    vectors++;
    if ({g, busy} !== 5'b0000_0) begin
      miscompares++;
      $display("FAIL sole_release: grant=%b busy=%b, required 0000 0", g, busy);
    end
  endtask

  task automatic test_drop_handoff();
    do_reset();
    set_req(4'b1001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({g, addr} !== 6'b0001_00) begin
        miscompares++;
        $display("FAIL drop_hold[%0d]: grant=%b addr=%b, required 0001 00", k, g, addr);
      end
    end
    set_req(4'b1000);
    @(negedge clk);
    vectors++;
    if ({g, addr, busy} !== 7'b1000_11_1) begin
      miscompares++;
      $display("FAIL drop_handoff: grant=%b addr=%b busy=%b, required 1000 11 1", g, addr, busy);
    end
    set_req(4'b0000);
    @(negedge clk);
  endtask

  task automatic test_successor();
    do_reset();
    set_req(4'b0100);
    @(negedge clk);
    set_req(4'b1101);
    @(negedge clk);
    vectors++;
    if ({g, addr} !== 6'b0100_10) begin
      miscompares++;
      $display("FAIL succ_hold: grant=%b addr=%b, required 0100 10", g, addr);
    end
    set_req(4'b1001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if ({g, addr} !== 6'b1000_11) begin
        miscompares++;
        $display("FAIL succ_to3[%0d]: grant=%b addr=%b, required 1000 11", k, g, addr);
      end
    end
    @(negedge clk);
    vectors++;
    if ({g, addr} !== 6'b0001_00) begin
      miscompares++;
      $display("FAIL succ_to0: grant=%b addr=%b, required 0001 00", g, addr);
    end
    set_req(4'b0000);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(4'b0010);
    @(negedge clk);
    vectors++;
    if (g !== 4'b0010) begin
      miscompares++;
      $display("FAIL areset_pre: grant=%b, required 0010", g);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({g, addr, busy} !== 7'b0000_00_0) begin
      miscompares++;
      $display("FAIL areset_async: grant=%b addr=%b busy=%b, required 0000 00 0",
               g, addr, busy);
    end
    set_req(4'b0011);
    #1 reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({g, addr, busy} !== 7'b0001_00_1) begin
      miscompares++;
      $display("FAIL areset_first: grant=%b addr=%b busy=%b, required 0001 00 1",
               g, addr, busy);
    end
    set_req(4'b0000);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_sole();
    test_drop_handoff();
    test_successor();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
